// File: rtl/lfsr_check.sv
// Receive-side PRBS checker: self-synchronises to a Galois LFSR stream, then free-runs and counts mismatches.
// Optional macro LFSR_CHECK_STUCK_EN adds a 'stuck' flag for the illegal all-zero word.
module lfsr_check #(
    parameter int             LEN      = 8,
    parameter logic [LEN-1:0] TAPS     = 8'b10111000,
    parameter int             LOCK_N   = 4,
    parameter int             UNLOCK_N = 4,
    parameter int             CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [LEN-1:0]   din,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
`ifdef LFSR_CHECK_STUCK_EN
    ,
    output logic             stuck
`endif
);
    localparam int GOOD_W = (LOCK_N + 1 > 2) ? $clog2(LOCK_N + 1) : 1;
    localparam int BAD_W  = (UNLOCK_N + 1 > 2) ? $clog2(UNLOCK_N + 1) : 1;

    typedef enum logic { SEEK, LOCK } state_t;

    state_t             state_reg, state_next;
    logic [LEN-1:0]     exp_reg, exp_next;
    logic [GOOD_W-1:0]  good_reg, good_next;
    logic [BAD_W-1:0]   bad_reg, bad_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               err_reg, err_next;
    logic               locked_reg;
    logic [LEN-1:0]     predicted;
    logic               zero_word;
    logic               match;

    function automatic logic [LEN-1:0] nxt(input logic [LEN-1:0] s);
        return {1'b0, s[LEN-1:1]} ^ (s[0] ? TAPS : '0);
    endfunction

    assign predicted = nxt(exp_reg);
`ifdef LFSR_CHECK_STUCK_EN
    assign zero_word = (din == '0);
`else
    assign zero_word = 1'b0;
`endif
    // An all-zero word is never a valid LFSR state, so it never counts as a match when the feature is on.
    assign match = (din == predicted) && !zero_word;

    always_comb begin
        state_next = state_reg;
        exp_next   = exp_reg;
        good_next  = good_reg;
        bad_next   = bad_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        if (en) begin
            case (state_reg)
                SEEK: begin
                    exp_next = din;
                    if (match) begin
                        if (good_reg == GOOD_W'(LOCK_N - 1)) begin
                            state_next = LOCK;
                            good_next  = '0;
                            bad_next   = '0;
                        end else begin
                            good_next = good_reg + 1'b1;
                        end
                    end else begin
                        good_next = '0;
                    end
                end
                default: begin
                    exp_next = predicted;
                    if (match) begin
                        bad_next = '0;
                    end else begin
                        err_next = 1'b1;
                        if (cnt_reg != '1) cnt_next = cnt_reg + 1'b1;
                        if (bad_reg == BAD_W'(UNLOCK_N - 1)) begin
                            state_next = SEEK;
                            exp_next   = din;
                            good_next  = '0;
                            bad_next   = '0;
                        end else begin
                            bad_next = bad_reg + 1'b1;
                        end
                    end
                end
            endcase
        end
        if (clear_cnt) cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= SEEK;
            exp_reg    <= '0;
            good_reg   <= '0;
            bad_reg    <= '0;
            cnt_reg    <= '0;
            err_reg    <= 1'b0;
            locked_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            exp_reg    <= exp_next;
            good_reg   <= good_next;
            bad_reg    <= bad_next;
            cnt_reg    <= cnt_next;
            err_reg    <= err_next;
            locked_reg <= (state_next == LOCK);
        end
    end

    assign locked  = locked_reg;
    assign err     = err_reg;
    assign err_cnt = cnt_reg;

`ifdef LFSR_CHECK_STUCK_EN
    logic stuck_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            stuck_reg <= 1'b0;
        end else if (en) begin
            stuck_reg <= zero_word;
        end
    end
    assign stuck = stuck_reg;
`endif
endmodule

// File: tb/tb_lfsr_check.sv
// Directed bench for lfsr_check: default-parameter instance driven from a vector table,
// plus a small-counter instance for saturation and clear.
module tb_lfsr_check;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        a_rst, a_en, a_clr;
    logic [7:0]  a_din;
    logic        a_locked, a_err;
    logic [15:0] a_cnt;
    // Instance B: CNT_W=4, UNLOCK_N=32
    logic        b_rst, b_en, b_clr;
    logic [7:0]  b_din;
    logic        b_locked, b_err;
    logic [3:0]  b_cnt;
`ifdef LFSR_CHECK_STUCK_EN
    logic a_stuck, b_stuck;
`endif

    lfsr_check dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .din(a_din), .clear_cnt(a_clr),
        .locked(a_locked), .err(a_err), .err_cnt(a_cnt)
`ifdef LFSR_CHECK_STUCK_EN
        , .stuck(a_stuck)
`endif
    );

    lfsr_check #(.UNLOCK_N(32), .CNT_W(4)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .din(b_din), .clear_cnt(b_clr),
        .locked(b_locked), .err(b_err), .err_cnt(b_cnt)
`ifdef LFSR_CHECK_STUCK_EN
        , .stuck(b_stuck)
`endif
    );

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input int act, input int req);
        nchk++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drive at the falling edge, sample 1 time unit after the following rising edge.
    task automatic step_a(input logic r, input logic e, input logic [7:0] d, input logic c);
        @(negedge clk);
        a_rst = r; a_en = e; a_din = d; a_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic r, input logic e, input logic [7:0] d, input logic c);
        @(negedge clk);
        b_rst = r; b_en = e; b_din = d; b_clr = c;
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        en;
        logic [7:0]  din;
        logic        clr;
        logic        locked;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_din = 8'h00; a_clr = 1'b0;
        b_rst = 1'b1; b_en = 1'b0; b_din = 8'h00; b_clr = 1'b0;

        //              en    din    clr   lock  err   cnt
        vecs.push_back({1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 16'd0});  // mismatch vs nxt(0)
        vecs.push_back({1'b1, 8'hC7, 1'b0, 1'b0, 1'b0, 16'd0});
        vecs.push_back({1'b1, 8'hDB, 1'b0, 1'b0, 1'b0, 16'd0});
        vecs.push_back({1'b1, 8'hD5, 1'b0, 1'b0, 1'b0, 16'd0});
        vecs.push_back({1'b1, 8'hD2, 1'b0, 1'b1, 1'b0, 16'd0});  // 4th match -> locked
        vecs.push_back({1'b1, 8'h69, 1'b0, 1'b1, 1'b0, 16'd0});
        vecs.push_back({1'b1, 8'h8D, 1'b0, 1'b1, 1'b1, 16'd1});  // expected 8C
        vecs.push_back({1'b1, 8'h46, 1'b0, 1'b1, 1'b0, 16'd1});  // free-running
        vecs.push_back({1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 16'd1});  // idle
        vecs.push_back({1'b1, 8'h23, 1'b0, 1'b1, 1'b0, 16'd1});
        vecs.push_back({1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 16'd2});
        vecs.push_back({1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 16'd3});
        vecs.push_back({1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 16'd4});
        vecs.push_back({1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 16'd5});  // 4th miss -> unlock
        vecs.push_back({1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 16'd5});  // vs nxt(55)=92
        vecs.push_back({1'b1, 8'hC7, 1'b0, 1'b0, 1'b0, 16'd5});
        vecs.push_back({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd5});
        vecs.push_back({1'b1, 8'hDB, 1'b0, 1'b0, 1'b0, 16'd5});
        vecs.push_back({1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 16'd5});
        vecs.push_back({1'b1, 8'hD5, 1'b0, 1'b0, 1'b0, 16'd5});
        vecs.push_back({1'b0, 8'hD2, 1'b0, 1'b0, 1'b0, 16'd5});
        vecs.push_back({1'b1, 8'hD2, 1'b0, 1'b1, 1'b0, 16'd5});  // relock through gaps
        vecs.push_back({1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'd0});  // clear
        vecs.push_back({1'b1, 8'h69, 1'b0, 1'b1, 1'b0, 16'd0});

        step_a(1'b1, 1'b0, 8'h00, 1'b0);
        step_a(1'b1, 1'b0, 8'h00, 1'b0);
        check("reset locked", a_locked, 0);
        check("reset err", a_err, 0);
        check("reset cnt", a_cnt, 0);
`ifdef LFSR_CHECK_STUCK_EN
        check("reset stuck", a_stuck, 0);
`endif

        foreach (vecs[i]) begin
            step_a(1'b0, vecs[i].en, vecs[i].din, vecs[i].clr);
            $display("vec %0d en=%0b din=%02h clr=%0b -> locked=%0b err=%0b cnt=%0d",
                     i, vecs[i].en, vecs[i].din, vecs[i].clr, a_locked, a_err, a_cnt);
            check($sformatf("vec%0d locked", i), a_locked, vecs[i].locked);
            check($sformatf("vec%0d err", i), a_err, vecs[i].err);
            check($sformatf("vec%0d cnt", i), a_cnt, vecs[i].cnt);
        end

        // Mismatch while locked (exp=69, expects 8C), then reset on a mismatching word
        step_a(1'b0, 1'b1, 8'h77, 1'b0);
        check("pre-reset err", a_err, 1);
        check("pre-reset cnt", a_cnt, 1);
        step_a(1'b1, 1'b1, 8'h33, 1'b0);
        $display("reset while locked -> locked=%0b err=%0b cnt=%0d", a_locked, a_err, a_cnt);
        check("mid-lock reset locked", a_locked, 0);
        check("mid-lock reset err", a_err, 0);
        check("mid-lock reset cnt", a_cnt, 0);

`ifdef LFSR_CHECK_STUCK_EN
        // Zeros always predicted from exp=0 but must never build toward lock
        for (int i = 0; i < 5; i++) begin
            step_a(1'b0, 1'b1, 8'h00, 1'b0);
            $display("zero word %0d -> stuck=%0b locked=%0b", i, a_stuck, a_locked);
            check($sformatf("zero%0d stuck", i), a_stuck, 1);
            check($sformatf("zero%0d locked", i), a_locked, 0);
        end
        step_a(1'b0, 1'b1, 8'hFF, 1'b0);
        check("stuck release", a_stuck, 0);
        step_a(1'b0, 1'b1, 8'hC7, 1'b0);
        step_a(1'b0, 1'b1, 8'hDB, 1'b0);
        step_a(1'b0, 1'b1, 8'hD5, 1'b0);
        step_a(1'b0, 1'b1, 8'hD2, 1'b0);
        check("stuck relock", a_locked, 1);
        step_a(1'b0, 1'b1, 8'h00, 1'b0);
        $display("zero in LOCK -> err=%0b cnt=%0d stuck=%0b", a_err, a_cnt, a_stuck);
        check("zero lock err", a_err, 1);
        check("zero lock cnt", a_cnt, 1);
        check("zero lock stuck", a_stuck, 1);
`endif
        step_a(1'b0, 1'b0, 8'h00, 1'b0);

        // Instance B: saturation and clear
        step_b(1'b1, 1'b0, 8'h00, 1'b0);
        step_b(1'b0, 1'b1, 8'hFF, 1'b0);
        step_b(1'b0, 1'b1, 8'hC7, 1'b0);
        step_b(1'b0, 1'b1, 8'hDB, 1'b0);
        step_b(1'b0, 1'b1, 8'hD5, 1'b0);
        step_b(1'b0, 1'b1, 8'hD2, 1'b0);
        check("B locked", b_locked, 1);
        for (int i = 1; i <= 20; i++) begin
            step_b(1'b0, 1'b1, 8'h55, 1'b0);
            $display("B miss %0d -> err=%0b cnt=%0d locked=%0b", i, b_err, b_cnt, b_locked);
            check($sformatf("B miss%0d cnt", i), b_cnt, (i > 15) ? 15 : i);
            check($sformatf("B miss%0d err", i), b_err, 1);
        end
        check("B still locked", b_locked, 1);
        step_b(1'b0, 1'b1, 8'h55, 1'b1);
        $display("B clear+miss -> err=%0b cnt=%0d", b_err, b_cnt);
        check("B clear cnt", b_cnt, 0);
        check("B clear err", b_err, 1);
        step_b(1'b0, 1'b0, 8'h00, 1'b0);
        check("B idle err", b_err, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
